store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- Sits between the load/store unit's store path and the write-through data cache write port, directly downstream of the core configuration.
- Holds translated stores speculatively until commit, then drains committed stores to the cache in program order.
- Bounds in-flight writes to the configured maximum and classifies each store as cacheable or non-cacheable from the cached-region rule.
- Provides the store-hazard query that the load path uses.

Parameters:
- DEPTH, 4: total entries (speculative + committed). Power of two, 2..16. Equals the scoreboard entry count.
- XLEN, 32: address and data width.
- MAX_OUTSTANDING, 7: maximum cache writes granted but not yet acked.
- CACHED_BASE, 32'h8000_0000: base of the cached region.
- CACHED_LEN, 32'h4000_0000: length of the cached region.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all uncommitted entries
- valid_i  in  1  new speculative store
- paddr_i  in  XLEN  physical address
- data_i  in  XLEN  store data
- be_i  in  XLEN/8  byte enables
- ready_o  out  1  space for one store
- commit_i  in  1  commit the oldest uncommitted store
- commit_ready_o  out  1  an uncommitted entry exists
- req_o  out  1  cache write request
- addr_o  out  XLEN  request address
- wdata_o  out  XLEN  request data
- be_o  out  XLEN/8  request byte enables
- noncacheable_o  out  1  request address lies outside the cached region
- gnt_i  in  1  cache accepted the request
- ack_i  in  1  one prior write completed
- page_offset_i  in  12  load page offset for the hazard check
- page_offset_match_o  out  1  hazard: a valid entry matches paddr[11:3]
- no_st_pending_o  out  1  buffer empty and zero writes outstanding

Behaviour:
- Storage: circular array of DEPTH entries {paddr, data, be, nc}.
  - Three pointers, each log2(DEPTH) bits and wrapping modulo DEPTH: issue_ptr (oldest committed), commit_ptr (oldest speculative), tail_ptr.
  - Two counters, each log2(DEPTH)+1 bits: cnt_committed and cnt_spec. Total occupancy = cnt_committed + cnt_spec.
- nc is computed at push: nc = !(paddr >= CACHED_BASE && paddr < CACHED_BASE+CACHED_LEN). The comparison is XLEN+1 bits so the sum does not wrap.
- ready_o = (total < DEPTH). A push is valid_i && ready_o: write the entry at tail_ptr, tail_ptr++, cnt_spec++. valid_i while ready_o=0 is dropped; checked by an assertion.
- commit_ready_o = (cnt_spec != 0). A commit is commit_i && commit_ready_o: commit_ptr++, cnt_spec--, cnt_committed++. commit_i with cnt_spec=0 is ignored; checked by an assertion.
- flush_i:
  - Sets tail_ptr := commit_ptr and cnt_spec := 0.
  - Committed entries are untouched.
  - A push in the flush cycle is discarded.
  - A commit in the flush cycle takes effect first: the committed entry survives and the remaining speculative entries are dropped.
- Issue: req_o = cnt_committed != 0 && outstanding < MAX_OUTSTANDING && (!entry[issue_ptr].nc || outstanding == 0).
  - Non-cacheable stores are issued only when nothing is outstanding, to preserve ordering.
  - addr_o, wdata_o, be_o and noncacheable_o are driven from entry[issue_ptr].
  - On req_o && gnt_i: issue_ptr++ and cnt_committed--.
  - Once req_o is high it stays high with stable data until gnt_i. Flush never retracts it.
- Outstanding counter: width $clog2(MAX_OUTSTANDING+1).
  - +1 on grant, -1 on ack_i. Grant and ack in the same cycle leave it unchanged.
  - ack_i at 0 is ignored; checked by an assertion.
- page_offset_match_o (combinational) = OR over every occupied entry (committed or speculative) of paddr[11:3] == page_offset_i[11:3].
- no_st_pending_o = total == 0 && outstanding == 0.
- Same-cycle push, commit, grant and ack are all legal, with independent counter updates.
  - A push when the buffer is full is refused even if a grant happens in the same cycle. ready_o does not depend combinationally on gnt_i.
- Reset (asynchronous, rst_ni=0): all pointers, counters and outstanding := 0.
  - Outputs after reset: ready_o=1, commit_ready_o=0, req_o=0, addr_o/wdata_o/be_o=0 (entry contents reset to 0), noncacheable_o=0, page_offset_match_o=0, no_st_pending_o=1.
  - Reset mid-transfer abandons outstanding writes.
- Latency: a store committed in cycle N can be requested in cycle N+1.

Decomposition:
- Shared package holds:
  - the entry typedef (store_entry_t)
  - the cacheability function is_cacheable(addr), driven by the cached-region base and length from the core configuration.
- One natural sub-module is store_outstanding_cnt: the saturating grant/ack up-down counter, which exposes can_issue and zero.

Test Plan:
- Reset, then push 0x8000_0010/0xDEADBEEF/be=F, commit, gnt_i=1 -> req_o in the cycle after commit with addr_o=0x8000_0010, noncacheable_o=0; after ack_i, no_st_pending_o=1.
- Push 4 stores -> ready_o=0 on the 5th cycle. Commit 2 and flush -> cnt_spec=0, the 2 committed entries drain in order and the 2 flushed entries never appear on req_o.
- Push and commit 0x1000_0000 while 1 write is outstanding -> noncacheable_o=1 and req_o=0 until ack_i; then req_o=1.
- Hold gnt_i=1 and ack_i=0 across 8 committed cacheable stores (DEPTH=8 variant) -> 7 grants, then req_o=0; one ack_i -> the 8th store issues next cycle.
- Valid entry with paddr 0x8000_0A48 and page_offset_i=0xA4C -> match=1; page_offset_i=0xA50 -> match=0.
- Drop rst_ni while req_o=1 with 3 writes outstanding -> outputs go to their reset values asynchronously and no_st_pending_o=1.

Source files
------------

// File: rtl/store_commit_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : store_commit_buffer_pkg                                      |
// | Description : Shared entry type and cacheability rule for the store buffer |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package store_commit_buffer_pkg;

    localparam int unsigned C_XLEN = 32;

    typedef struct packed {
        logic [C_XLEN-1:0]   paddr;
        logic [C_XLEN-1:0]   data;
        logic [C_XLEN/8-1:0] be;
        logic                nc;
    } store_entry_t;

    // One extra bit keeps base+len from wrapping at the top of the address space.
    function automatic logic is_cacheable(
        input logic [C_XLEN-1:0] addr,
        input logic [C_XLEN-1:0] base,
        input logic [C_XLEN-1:0] len
    );
        logic [C_XLEN:0] w_end;
        w_end = {1'b0, base} + {1'b0, len};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < w_end);
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_commit_buffer_outstanding.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : store_outstanding_cnt                                        |
// | Description : Saturating count of cache writes granted but not yet acked   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module store_outstanding_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 7
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic grant_i,
    input  logic ack_i,
    output logic can_issue_o,
    output logic zero_o
);

    localparam int unsigned C_W = $clog2(MAX_OUTSTANDING + 1);

    logic [C_W-1:0] r_cnt;
    logic           w_inc;
    logic           w_dec;

    assign w_inc = grant_i && (r_cnt != C_W'(MAX_OUTSTANDING));
    assign w_dec = ack_i && (r_cnt != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + C_W'(1);
        end else if (!w_inc && w_dec) begin
            r_cnt <= r_cnt - C_W'(1);
        end
    end

    assign can_issue_o = (r_cnt < C_W'(MAX_OUTSTANDING));
    assign zero_o      = (r_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(ack_i && zero_o));
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_commit_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : store_commit_buffer                                          |
// | Description : Speculative store buffer draining committed stores in order  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int unsigned       DEPTH           = 4,
    parameter int unsigned       XLEN            = 32,
    parameter int unsigned       MAX_OUTSTANDING = 7,
    parameter logic [XLEN-1:0]   CACHED_BASE     = 32'h8000_0000,
    parameter logic [XLEN-1:0]   CACHED_LEN      = 32'h4000_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [XLEN-1:0]   paddr_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic [XLEN/8-1:0] be_i,
    output logic              ready_o,
    input  logic              commit_i,
    output logic              commit_ready_o,
    output logic              req_o,
    output logic [XLEN-1:0]   addr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN/8-1:0] be_o,
    output logic              noncacheable_o,
    input  logic              gnt_i,
    input  logic              ack_i,
    input  logic [11:0]       page_offset_i,
    output logic              page_offset_match_o,
    output logic              no_st_pending_o
);

    localparam int unsigned C_PTR_W = $clog2(DEPTH);
    localparam int unsigned C_CNT_W = C_PTR_W + 1;

    store_entry_t         r_entries [DEPTH];
    logic [C_PTR_W-1:0]   r_issue_ptr;
    logic [C_PTR_W-1:0]   r_commit_ptr;
    logic [C_PTR_W-1:0]   r_tail_ptr;
    logic [C_CNT_W-1:0]   r_cnt_committed;
    logic [C_CNT_W-1:0]   r_cnt_spec;

    logic [C_CNT_W-1:0]   w_total;
    logic                 w_push;
    logic                 w_commit;
    logic                 w_grant;
    logic                 w_can_issue;
    logic                 w_out_zero;
    logic [C_PTR_W-1:0]   w_commit_ptr_nxt;
    store_entry_t         w_new_entry;
    store_entry_t         w_head;
    logic [DEPTH-1:0]     w_hit;
    logic                 w_unused_offset_bits;

    assign w_total        = r_cnt_committed + r_cnt_spec;
    assign ready_o        = (w_total < C_CNT_W'(DEPTH));
    assign commit_ready_o = (r_cnt_spec != '0);

    // A push coinciding with a flush belongs to the discarded speculative path.
    assign w_push           = valid_i && ready_o && !flush_i;
    assign w_commit         = commit_i && commit_ready_o;
    assign w_grant          = req_o && gnt_i;
    assign w_commit_ptr_nxt = r_commit_ptr + C_PTR_W'(w_commit);

    always_comb begin
        w_new_entry       = '0;
        w_new_entry.paddr = paddr_i;
        w_new_entry.data  = data_i;
        w_new_entry.be    = be_i;
        w_new_entry.nc    = !is_cacheable(paddr_i, CACHED_BASE, CACHED_LEN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (w_push) begin
            r_entries[r_tail_ptr] <= w_new_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_issue_ptr     <= '0;
            r_commit_ptr    <= '0;
            r_tail_ptr      <= '0;
            r_cnt_committed <= '0;
            r_cnt_spec      <= '0;
        end else begin
            r_issue_ptr     <= r_issue_ptr + C_PTR_W'(w_grant);
            r_commit_ptr    <= w_commit_ptr_nxt;
            r_cnt_committed <= r_cnt_committed + C_CNT_W'(w_commit) - C_CNT_W'(w_grant);
            if (flush_i) begin
                r_tail_ptr <= w_commit_ptr_nxt;
                r_cnt_spec <= '0;
            end else begin
                r_tail_ptr <= r_tail_ptr + C_PTR_W'(w_push);
                r_cnt_spec <= r_cnt_spec + C_CNT_W'(w_push) - C_CNT_W'(w_commit);
            end
        end
    end

    store_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .grant_i     (w_grant),
        .ack_i       (ack_i),
        .can_issue_o (w_can_issue),
        .zero_o      (w_out_zero)
    );

    // Non-cacheable writes wait for an empty pipe so they cannot overtake earlier writes.
    assign w_head         = r_entries[r_issue_ptr];
    assign req_o          = (r_cnt_committed != '0) && w_can_issue && (!w_head.nc || w_out_zero);
    assign addr_o         = w_head.paddr;
    assign wdata_o        = w_head.data;
    assign be_o           = w_head.be;
    assign noncacheable_o = w_head.nc;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        logic [C_PTR_W-1:0] w_rel;
        assign w_rel      = C_PTR_W'(gi) - r_issue_ptr;
        assign w_hit[gi]  = ({1'b0, w_rel} < w_total)
                         && (r_entries[gi].paddr[11:3] == page_offset_i[11:3]);
    end

    assign page_offset_match_o  = |w_hit;
    assign no_st_pending_o      = (w_total == '0) && w_out_zero;
    assign w_unused_offset_bits = ^page_offset_i[2:0];

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(valid_i && !ready_o));
            assert (!(commit_i && !commit_ready_o));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_commit_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_store_commit_buffer                                       |
// | Description : Self-checking bench with a write-order scoreboard            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_store_commit_buffer;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic [31:0] paddr_i;
    logic [31:0] data_i;
    logic [3:0]  be_i;
    logic        ready_o;
    logic        commit_i;
    logic        commit_ready_o;
    logic        req_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        noncacheable_o;
    logic        gnt_i;
    logic        ack_i;
    logic [11:0] page_offset_i;
    logic        page_offset_match_o;
    logic        no_st_pending_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        nc;
    } exp_t;

    typedef struct {
        logic [31:0] paddr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [11:0] query;
        logic        exp_nc;
        logic        exp_match;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs [8];
    int   n_checks = 0;
    int   n_errors = 0;

    store_commit_buffer #(
        .DEPTH           (4),
        .XLEN            (32),
        .MAX_OUTSTANDING (7),
        .CACHED_BASE     (32'h8000_0000),
        .CACHED_LEN      (32'h4000_0000)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .valid_i             (valid_i),
        .paddr_i             (paddr_i),
        .data_i              (data_i),
        .be_i                (be_i),
        .ready_o             (ready_o),
        .commit_i            (commit_i),
        .commit_ready_o      (commit_ready_o),
        .req_o               (req_o),
        .addr_o              (addr_o),
        .wdata_o             (wdata_o),
        .be_o                (be_o),
        .noncacheable_o      (noncacheable_o),
        .gnt_i               (gnt_i),
        .ack_i               (ack_i),
        .page_offset_i       (page_offset_i),
        .page_offset_match_o (page_offset_match_o),
        .no_st_pending_o     (no_st_pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input logic nc);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.be   = b;
        e.nc   = nc;
        sb_q.push_back(e);
    endtask

    task automatic push_commit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input logic nc);
        valid_i = 1'b1;
        paddr_i = a;
        data_i  = d;
        be_i    = b;
        cyc();
        valid_i  = 1'b0;
        commit_i = 1'b1;
        sb_push(a, d, b, nc);
        cyc();
        commit_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   32'(ready_o), 32'd1);
        check({tag, "_cready"},  32'(commit_ready_o), 32'd0);
        check({tag, "_req"},     32'(req_o), 32'd0);
        check({tag, "_addr"},    addr_o, 32'd0);
        check({tag, "_wdata"},   wdata_o, 32'd0);
        check({tag, "_be"},      32'(be_o), 32'd0);
        check({tag, "_nc"},      32'(noncacheable_o), 32'd0);
        check({tag, "_match"},   32'(page_offset_match_o), 32'd0);
        check({tag, "_nopend"},  32'(no_st_pending_o), 32'd1);
    endtask

    // Every granted request must be the oldest committed store still expected.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && req_o && gnt_i) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got grant of addr 0x%h, expected no request", addr_o);
            end else begin
                e = sb_q.pop_front();
                check("sb_addr",  addr_o, e.addr);
                check("sb_wdata", wdata_o, e.data);
                check("sb_be",    32'(be_o), 32'(e.be));
                check("sb_nc",    32'(noncacheable_o), 32'(e.nc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h8000_0A48, 32'h1111_0001, 4'hF, 12'hA4C, 1'b0, 1'b1};
        vecs[1] = '{32'h8000_0A48, 32'h1111_0002, 4'h3, 12'hA50, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFF_FFFC, 32'h1111_0003, 4'h8, 12'hFF8, 1'b1, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h1111_0004, 4'h1, 12'h000, 1'b0, 1'b1};
        vecs[4] = '{32'hBFFF_FFFC, 32'h1111_0005, 4'hC, 12'h7FC, 1'b0, 1'b0};
        vecs[5] = '{32'hC000_0000, 32'h1111_0006, 4'hF, 12'h007, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFF_FFF0, 32'h1111_0007, 4'h6, 12'hFF0, 1'b1, 1'b1};
        vecs[7] = '{32'h0000_0000, 32'h1111_0008, 4'h2, 12'h008, 1'b1, 1'b0};

        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; paddr_i = '0; data_i = '0;
        be_i = '0; commit_i = 1'b0; gnt_i = 1'b0; ack_i = 1'b0; page_offset_i = '0;
        repeat (2) cyc();
        @(negedge clk_i);
        check_reset_outputs("rst");
        cyc();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("rst_rel");

        // Single cacheable store: request appears the cycle after commit.
        cyc();
        valid_i = 1'b1; paddr_i = 32'h8000_0010; data_i = 32'hDEAD_BEEF; be_i = 4'hF;
        cyc();
        valid_i = 1'b0; commit_i = 1'b1;
        sb_push(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        @(negedge clk_i);
        check("b_req_before", 32'(req_o), 32'd0);
        check("b_cready", 32'(commit_ready_o), 32'd1);
        cyc();
        commit_i = 1'b0; gnt_i = 1'b1;
        @(negedge clk_i);
        check("b_req_after", 32'(req_o), 32'd1);
        cyc();
        gnt_i = 1'b0;
        @(negedge clk_i);
        check("b_pend", 32'(no_st_pending_o), 32'd0);
        cyc();
        ack_i = 1'b1;
        cyc();
        ack_i = 1'b0;
        @(negedge clk_i);
        check("b_nopend", 32'(no_st_pending_o), 32'd1);

        // Fill, commit two (second together with flush), then drain in order.
        for (int i = 0; i < 4; i++) begin
            cyc();
            valid_i = 1'b1; paddr_i = 32'h8000_0100 + 32'(i) * 32'h10;
            data_i = 32'hA000_0000 + 32'(i); be_i = 4'hF;
        end
        cyc();
        valid_i = 1'b0;
        page_offset_i = 12'h130;
        @(negedge clk_i);
        check("c_full_ready", 32'(ready_o), 32'd0);
        check("c_full_match", 32'(page_offset_match_o), 32'd1);
        check("c_full_req", 32'(req_o), 32'd0);
        cyc();
        commit_i = 1'b1;
        sb_push(32'h8000_0100, 32'hA000_0000, 4'hF, 1'b0);
        cyc();
        flush_i = 1'b1;
        sb_push(32'h8000_0110, 32'hA000_0001, 4'hF, 1'b0);
        cyc();
        commit_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check("c_flush_cready", 32'(commit_ready_o), 32'd0);
        check("c_flush_ready", 32'(ready_o), 32'd1);
        check("c_flush_match", 32'(page_offset_match_o), 32'd0);
        check("c_flush_req", 32'(req_o), 32'd1);
        cyc();
        valid_i = 1'b1; paddr_i = 32'h8000_0180; data_i = 32'hA000_0004; be_i = 4'h5;
        cyc();
        valid_i = 1'b0; commit_i = 1'b1;
        sb_push(32'h8000_0180, 32'hA000_0004, 4'h5, 1'b0);
        cyc();
        commit_i = 1'b0; gnt_i = 1'b1;
        repeat (3) cyc();
        gnt_i = 1'b0;
        @(negedge clk_i);
        check("c_drained_req", 32'(req_o), 32'd0);
        cyc();
        ack_i = 1'b1;
        repeat (3) cyc();
        ack_i = 1'b0;
        @(negedge clk_i);
        check("c_nopend", 32'(no_st_pending_o), 32'd1);

        // Non-cacheable store waits for the outstanding cacheable write.
        cyc();
        gnt_i = 1'b1;
        push_commit(32'h8000_0200, 32'hB000_0000, 4'hF, 1'b0);
        push_commit(32'h1000_0000, 32'h1234_5678, 4'h3, 1'b1);
        @(negedge clk_i);
        check("d_nc_req0", 32'(req_o), 32'd0);
        check("d_nc_flag", 32'(noncacheable_o), 32'd1);
        cyc();
        @(negedge clk_i);
        check("d_nc_req1", 32'(req_o), 32'd0);
        cyc();
        ack_i = 1'b1;
        @(negedge clk_i);
        check("d_nc_req_ack", 32'(req_o), 32'd0);
        cyc();
        ack_i = 1'b0;
        @(negedge clk_i);
        check("d_nc_req_go", 32'(req_o), 32'd1);
        cyc();
        gnt_i = 1'b0; ack_i = 1'b1;
        cyc();
        ack_i = 1'b0;
        @(negedge clk_i);
        check("d_nopend", 32'(no_st_pending_o), 32'd1);

        // Outstanding limit: seven grants, the eighth waits for an ack.
        cyc();
        gnt_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push_commit(32'h8000_0300 + 32'(i) * 32'h8, 32'hC000_0000 + 32'(i), 4'hF, 1'b0);
        end
        push_commit(32'h8000_0400, 32'hC000_0008, 4'h9, 1'b0);
        @(negedge clk_i);
        check("e_limit_req0", 32'(req_o), 32'd0);
        cyc();
        @(negedge clk_i);
        check("e_limit_req1", 32'(req_o), 32'd0);
        cyc();
        ack_i = 1'b1;
        @(negedge clk_i);
        check("e_limit_req_ack", 32'(req_o), 32'd0);
        cyc();
        ack_i = 1'b0;
        @(negedge clk_i);
        check("e_limit_req_go", 32'(req_o), 32'd1);
        cyc();
        gnt_i = 1'b0; ack_i = 1'b1;
        repeat (7) cyc();
        ack_i = 1'b0;
        @(negedge clk_i);
        check("e_nopend", 32'(no_st_pending_o), 32'd1);

        // Table: cacheability boundaries and hazard matching.
        for (int v = 0; v < 8; v++) begin
            cyc();
            page_offset_i = vecs[v].query;
            valid_i = 1'b1; paddr_i = vecs[v].paddr; data_i = vecs[v].data; be_i = vecs[v].be;
            cyc();
            valid_i = 1'b0;
            @(negedge clk_i);
            check($sformatf("f_match_%0d", v), 32'(page_offset_match_o), 32'(vecs[v].exp_match));
            cyc();
            commit_i = 1'b1;
            sb_push(vecs[v].paddr, vecs[v].data, vecs[v].be, vecs[v].exp_nc);
            cyc();
            commit_i = 1'b0; gnt_i = 1'b1;
            @(negedge clk_i);
            check($sformatf("f_req_%0d", v), 32'(req_o), 32'd1);
            cyc();
            gnt_i = 1'b0; ack_i = 1'b1;
            cyc();
            ack_i = 1'b0;
        end
        page_offset_i = '0;
        @(negedge clk_i);
        check("f_nopend", 32'(no_st_pending_o), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset while a request is pending with three writes outstanding.
        cyc();
        gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_commit(32'h8000_0500 + 32'(i) * 32'h8, 32'hD000_0000 + 32'(i), 4'hF, 1'b0);
        end
        push_commit(32'h8000_0600, 32'hD000_0003, 4'hF, 1'b0);
        gnt_i = 1'b0;
        page_offset_i = 12'h600;
        @(negedge clk_i);
        check("g_req_before", 32'(req_o), 32'd1);
        check("g_pend_before", 32'(no_st_pending_o), 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("g_async");
        sb_q.delete();
        cyc();
        cyc();
        rst_ni = 1'b1;
        page_offset_i = '0;
        @(negedge clk_i);
        check_reset_outputs("g_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
